quiz_round_ctrl: RTL and testbench

- Round sequencer for the factorization quiz.
- Requests a problem from the question generator, opens answer entry, and enforces a per-question countdown from the 1-second tick.
- Hands the committed answer to the judge, then updates hit points and question count.
- Declares game clear or game over. Sits between the button/input logic and the question/judge datapath; drives STATE for the display block.

---
 rtl/quiz_pkg.sv | 30 +++
 rtl/sec_countdown.sv | 28 ++
 rtl/quiz_round_ctrl.sv | 151 +++++++++++++++
 tb/tb_quiz_round_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared state codes, judge codes and widths for the quiz round controller
package quiz_pkg;

    localparam int HP_W   = 2;
    localparam int QN_W   = 4;
    localparam int TIME_W = 6;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_GEN    = 4'd1;
    localparam logic [3:0] ST_ANSWER = 4'd2;
    localparam logic [3:0] ST_JUDGE  = 4'd3;
    localparam logic [3:0] ST_RESULT = 4'd4;
    localparam logic [3:0] ST_CLEAR  = 4'd5;
    localparam logic [3:0] ST_OVER   = 4'd6;

    localparam logic [1:0] JUDG_PENDING = 2'b00;
    localparam logic [1:0] JUDG_CORRECT = 2'b01;
    localparam logic [1:0] JUDG_WRONG   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_GEN    = ST_GEN,
        S_ANSWER = ST_ANSWER,
        S_JUDGE  = ST_JUDGE,
        S_RESULT = ST_RESULT,
        S_CLEAR  = ST_CLEAR,
        S_OVER   = ST_OVER
    } state_t;

endpackage

// File: rtl/sec_countdown.sv
// rtl/sec_countdown.sv - loadable seconds down-counter with zero saturation and expire pulse
module sec_countdown #(
    parameter int             W         = 6,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         expire
);

    // expire is combinational so the owner can leave its state on the same edge the count hits 0
    assign expire = tick && !load && (count == W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// rtl/quiz_round_ctrl.sv - quiz round sequencer; TIMEOUT_EN enables the per-question countdown
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int HP_INIT    = 3,
    parameter int NUM_Q      = 5,
    parameter int TIME_LIMIT = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START_IN,
    input  logic              TICK_1S,
    input  logic              QGEN_DONE,
    input  logic              ANS_VALID,
    input  logic [1:0]        JUDG_IN,
    output logic              QGEN_REQ,
    output logic              ANS_EN,
    output logic              JUDGE_REQ,
    output logic [HP_W-1:0]   HP_OUT,
    output logic [QN_W-1:0]   Q_NUM,
    output logic [TIME_W-1:0] TIME_LEFT,
    output logic [3:0]        STATE,
    output logic              CLR_OUT,
    output logic              OVER_OUT
);

    localparam logic [HP_W-1:0]   HP_RST  = HP_W'(HP_INIT);
    localparam logic [QN_W-1:0]   NUM_Q_V = QN_W'(NUM_Q);
    localparam logic [TIME_W-1:0] TL_V    = TIME_W'(TIME_LIMIT);

    state_t state;
    logic   verdict_ok;
    logic   expire;

    assign STATE = state;

`ifdef TIMEOUT_EN
    sec_countdown #(
        .W         (TIME_W),
        .RESET_VAL (TL_V)
    ) u_countdown (
        .clk      (CLK),
        .rst_n    (RST),
        .load     ((state == S_GEN) && QGEN_DONE),
        .load_val (TL_V),
        .tick     ((state == S_ANSWER) && TICK_1S),
        .count    (TIME_LEFT),
        .expire   (expire)
    );
`else
    logic unused_tick;
    assign unused_tick = TICK_1S;
    assign TIME_LEFT   = TL_V;
    assign expire      = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            HP_OUT     <= HP_RST;
            Q_NUM      <= '0;
            QGEN_REQ   <= 1'b0;
            ANS_EN     <= 1'b0;
            JUDGE_REQ  <= 1'b0;
            CLR_OUT    <= 1'b0;
            OVER_OUT   <= 1'b0;
            verdict_ok <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START_IN) begin
                        state    <= S_GEN;
                        HP_OUT   <= HP_RST;
                        Q_NUM    <= '0;
                        QGEN_REQ <= 1'b1;
                    end
                end
                S_GEN: begin
                    if (QGEN_DONE) begin
                        state    <= S_ANSWER;
                        QGEN_REQ <= 1'b0;
                        ANS_EN   <= 1'b1;
                    end
                end
                S_ANSWER: begin
                    // a committed answer beats an expiring tick in the same cycle
                    if (ANS_VALID) begin
                        state     <= S_JUDGE;
                        ANS_EN    <= 1'b0;
                        JUDGE_REQ <= 1'b1;
                    end else if (expire) begin
                        state      <= S_RESULT;
                        ANS_EN     <= 1'b0;
                        verdict_ok <= 1'b0;
                    end
                end
                S_JUDGE: begin
                    if (JUDG_IN != JUDG_PENDING) begin
                        state      <= S_RESULT;
                        JUDGE_REQ  <= 1'b0;
                        verdict_ok <= (JUDG_IN == JUDG_CORRECT);
                    end
                end
                S_RESULT: begin
                    if (verdict_ok) begin
                        if (Q_NUM != NUM_Q_V) begin
                            Q_NUM <= Q_NUM + 1'b1;
                        end
                        if (Q_NUM + 1'b1 == NUM_Q_V) begin
                            state   <= S_CLEAR;
                            CLR_OUT <= 1'b1;
                        end else begin
                            state    <= S_GEN;
                            QGEN_REQ <= 1'b1;
                        end
                    end else begin
                        if (HP_OUT != '0) begin
                            HP_OUT <= HP_OUT - 1'b1;
                        end
                        if (HP_OUT <= HP_W'(1)) begin
                            state    <= S_OVER;
                            OVER_OUT <= 1'b1;
                        end else begin
                            state    <= S_GEN;
                            QGEN_REQ <= 1'b1;
                        end
                    end
                end
                S_CLEAR, S_OVER: begin
                    if (START_IN) begin
                        state    <= S_GEN;
                        HP_OUT   <= HP_RST;
                        Q_NUM    <= '0;
                        QGEN_REQ <= 1'b1;
                        CLR_OUT  <= 1'b0;
                        OVER_OUT <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    QGEN_REQ  <= 1'b0;
                    ANS_EN    <= 1'b0;
                    JUDGE_REQ <= 1'b0;
                    CLR_OUT   <= 1'b0;
                    OVER_OUT  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb/tb_quiz_round_ctrl.sv - directed self-checking bench for quiz_round_ctrl
module tb_quiz_round_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START_IN = 1'b0;
    logic       TICK_1S = 1'b0;
    logic       QGEN_DONE = 1'b0;
    logic       ANS_VALID = 1'b0;
    logic [1:0] JUDG_IN = 2'b00;
    logic       QGEN_REQ, ANS_EN, JUDGE_REQ, CLR_OUT, OVER_OUT;
    logic [1:0] HP_OUT;
    logic [3:0] Q_NUM;
    logic [5:0] TIME_LEFT;
    logic [3:0] STATE;

    int n_cmp = 0;
    int n_bad = 0;

    quiz_round_ctrl #(
        .HP_INIT    (3),
        .NUM_Q      (5),
        .TIME_LIMIT (20)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START_IN  (START_IN),
        .TICK_1S   (TICK_1S),
        .QGEN_DONE (QGEN_DONE),
        .ANS_VALID (ANS_VALID),
        .JUDG_IN   (JUDG_IN),
        .QGEN_REQ  (QGEN_REQ),
        .ANS_EN    (ANS_EN),
        .JUDGE_REQ (JUDGE_REQ),
        .HP_OUT    (HP_OUT),
        .Q_NUM     (Q_NUM),
        .TIME_LEFT (TIME_LEFT),
        .STATE     (STATE),
        .CLR_OUT   (CLR_OUT),
        .OVER_OUT  (OVER_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START_IN = 1'b1;
        step();
        START_IN = 1'b0;
    endtask

    task automatic pulse_qgen();
        QGEN_DONE = 1'b1;
        step();
        QGEN_DONE = 1'b0;
        check("gen_to_answer", STATE, 2);
        check("ans_en_on", ANS_EN, 1);
        check("qgen_req_off", QGEN_REQ, 0);
        check("time_reload", TIME_LEFT, 20);
    endtask

    // from ANSWER: commit, hold one pending cycle, deliver verdict, then apply RESULT
    task automatic judge_round(input logic [1:0] jv);
        ANS_VALID = 1'b1;
        step();
        ANS_VALID = 1'b0;
        check("answer_to_judge", STATE, 3);
        check("judge_req_on", JUDGE_REQ, 1);
        check("ans_en_off", ANS_EN, 0);
        step();
        check("judge_pending", STATE, 3);
        JUDG_IN = jv;
        step();
        JUDG_IN = 2'b00;
        check("judge_to_result", STATE, 4);
        check("judge_req_off", JUDGE_REQ, 0);
        step();
    endtask

    initial begin
        step();
        step();
        check("rst_state", STATE, 0);
        check("rst_hp", HP_OUT, 3);
        check("rst_qnum", Q_NUM, 0);
        check("rst_time", TIME_LEFT, 20);
        check("rst_qgen_req", QGEN_REQ, 0);
        check("rst_ans_en", ANS_EN, 0);
        check("rst_judge_req", JUDGE_REQ, 0);
        check("rst_clr", CLR_OUT, 0);
        check("rst_over", OVER_OUT, 0);
        RST = 1'b1;

        // full clear
        step();
        check("idle_hold", STATE, 0);
        pulse_start();
        check("idle_to_gen", STATE, 1);
        check("qgen_req_on", QGEN_REQ, 1);
        step();
        check("gen_hold_req", QGEN_REQ, 1);
        pulse_qgen();
        for (int i = 1; i <= 5; i++) begin
            judge_round(2'b01);
            check("clear_qnum", Q_NUM, i);
            check("clear_hp", HP_OUT, 3);
            if (i < 5) begin
                check("correct_to_gen", STATE, 1);
                check("correct_qgen_req", QGEN_REQ, 1);
                pulse_qgen();
            end else begin
                check("clear_state", STATE, 5);
                check("clear_flag", CLR_OUT, 1);
            end
        end
        step();
        check("clear_hold", CLR_OUT, 1);

        // game over, restarting from CLEAR
        pulse_start();
        check("restart_gen", STATE, 1);
        check("restart_clr_off", CLR_OUT, 0);
        check("restart_qnum", Q_NUM, 0);
        pulse_qgen();
        for (int i = 1; i <= 3; i++) begin
            judge_round((i == 2) ? 2'b10 : 2'b11);
            check("over_hp", HP_OUT, 3 - i);
            check("over_qnum", Q_NUM, 0);
            if (i < 3) begin
                check("wrong_to_gen", STATE, 1);
                pulse_qgen();
            end else begin
                check("over_state", STATE, 6);
                check("over_flag", OVER_OUT, 1);
            end
        end
        ANS_VALID = 1'b1;
        step();
        ANS_VALID = 1'b0;
        check("over_ignores_ans", STATE, 6);

        // reset while JUDGE_REQ is held, after losing one hit point
        pulse_start();
        check("over_restart_gen", STATE, 1);
        check("over_restart_flag", OVER_OUT, 0);
        check("over_restart_hp", HP_OUT, 3);
        pulse_qgen();
        judge_round(2'b11);
        check("pre_reset_hp", HP_OUT, 2);
        pulse_qgen();
        ANS_VALID = 1'b1;
        step();
        ANS_VALID = 1'b0;
        pulse_start();
        check("judge_ignores_start", STATE, 3);
        check("judge_req_held", JUDGE_REQ, 1);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_state", STATE, 0);
        check("async_rst_judge_req", JUDGE_REQ, 0);
        check("async_rst_hp", HP_OUT, 3);
        step();
        RST = 1'b1;
        step();
        check("post_rst_idle", STATE, 0);

        // countdown behaviour
        pulse_start();
        pulse_qgen();
`ifdef TIMEOUT_EN
        for (int i = 1; i <= 19; i++) begin
            TICK_1S = 1'b1;
            step();
            TICK_1S = 0;
            check("tick_count", TIME_LEFT, 20 - i);
        end
        check("before_expire", STATE, 2);
        TICK_1S = 1'b1;
        step();
        TICK_1S = 1'b0;
        check("timeout_result", STATE, 4);
        check("timeout_time", TIME_LEFT, 0);
        check("timeout_ans_en", ANS_EN, 0);
        check("timeout_hp_pending", HP_OUT, 3);
        step();
        check("timeout_to_gen", STATE, 1);
        check("timeout_hp", HP_OUT, 2);
        pulse_qgen();
        for (int i = 1; i <= 19; i++) begin
            TICK_1S = 1'b1;
            step();
            TICK_1S = 1'b0;
        end
        check("race_time_one", TIME_LEFT, 1);
        TICK_1S = 1'b1;
        ANS_VALID = 1'b1;
        step();
        TICK_1S = 1'b0;
        ANS_VALID = 1'b0;
        check("race_judge", STATE, 3);
        check("race_time_zero", TIME_LEFT, 0);
        check("race_hp", HP_OUT, 2);
        TICK_1S = 1'b1;
        step();
        TICK_1S = 1'b0;
        check("judge_ignores_tick", STATE, 3);
        JUDG_IN = 2'b01;
        step();
        JUDG_IN = 2'b00;
        step();
        check("race_qnum", Q_NUM, 1);
        check("race_hp_after", HP_OUT, 2);
        check("race_gen", STATE, 1);
`else
        for (int i = 1; i <= 25; i++) begin
            TICK_1S = 1'b1;
            step();
            TICK_1S = 1'b0;
        end
        check("no_timeout_time", TIME_LEFT, 20);
        check("no_timeout_state", STATE, 2);
        check("no_timeout_ans_en", ANS_EN, 1);
        judge_round(2'b01);
        check("no_timeout_qnum", Q_NUM, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
